// File: rtl/cva6v_vector_bank_ctrl.sv
// ============================================================================
// Module  : cva6v_vector_bank_ctrl
// Purpose : Single-port SRAM bank controller with read-modify-write for
//           partial-strobe writes and a fixed-latency response path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cva6v_vector_bank_ctrl #(
  parameter int unsigned AddrWidth             = 32,
  parameter int unsigned DataWidth             = 32,
  parameter int unsigned MemoryResponseLatency = 1,
  localparam int unsigned StrbWidth            = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  output logic                 p_valid_o,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic [StrbWidth-1:0] strb_q;
  logic                 rsp_valid_q;
  logic                 rsp_read_q;

  logic                 w_accept;
  logic                 w_merge_load;
  logic [DataWidth-1:0] w_rsp_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    q_ready_o    = 1'b0;
    w_accept     = 1'b0;
    w_merge_load = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = q_addr_i;
    sram_wdata_o = q_data_i;
    case (state_q)
      IDLE: begin
        q_ready_o = ~rst_i;
        if (q_valid_i && !rst_i) begin
          w_accept = 1'b1;
          if (!q_write_i) begin
            sram_req_o = 1'b1;
          end else if (&q_strb_i) begin
            sram_req_o = 1'b1;
            sram_we_o  = 1'b1;
          end else if (|q_strb_i) begin
            // Partial write: fetch the old word now, write the merge next cycle.
            sram_req_o   = 1'b1;
            w_merge_load = 1'b1;
            state_d      = MERGE;
          end
        end
      end
      MERGE: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = addr_q;
        for (int b = 0; b < int'(StrbWidth); b++) begin
          sram_wdata_o[8*b +: 8] = strb_q[b] ? data_q[8*b +: 8] : sram_rdata_i[8*b +: 8];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (w_merge_load) begin
      addr_q <= q_addr_i;
      data_q <= q_data_i;
      strb_q <= q_strb_i;
    end
  end

  // First response stage: SRAM read data is valid one cycle after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= w_accept;
      rsp_read_q  <= w_accept & ~q_write_i;
    end
  end

  assign w_rsp_data = (rsp_valid_q && rsp_read_q) ? sram_rdata_i : '0;

  if (MemoryResponseLatency == 1) begin : g_lat1
    assign p_valid_o = rsp_valid_q;
    assign p_data_o  = w_rsp_data;
  end else begin : g_pipe
    localparam int unsigned Stages = MemoryResponseLatency - 1;
    logic [Stages-1:0]    pipe_valid_q;
    logic [DataWidth-1:0] pipe_data_q [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe_valid_q <= '0;
        for (int i = 0; i < int'(Stages); i++) begin
          pipe_data_q[i] <= '0;
        end
      end else begin
        pipe_valid_q[0] <= rsp_valid_q;
        pipe_data_q[0]  <= w_rsp_data;
        for (int i = 1; i < int'(Stages); i++) begin
          pipe_valid_q[i] <= pipe_valid_q[i-1];
          pipe_data_q[i]  <= pipe_data_q[i-1];
        end
      end
    end

    assign p_valid_o = pipe_valid_q[Stages-1];
    assign p_data_o  = pipe_data_q[Stages-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_cva6v_vector_bank_ctrl.sv
// ============================================================================
// Module  : tb_cva6v_vector_bank_ctrl
// Purpose : Directed bench for the bank controller with a behavioural SRAM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cva6v_vector_bank_ctrl;

  localparam int LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        q_valid_i = 1'b0;
  logic        q_ready_o;
  logic [31:0] q_addr_i = '0;
  logic        q_write_i = 1'b0;
  logic [31:0] q_data_i = '0;
  logic [3:0]  q_strb_i = '0;
  logic        p_valid_o;
  logic [31:0] p_data_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;

  cva6v_vector_bank_ctrl #(
    .AddrWidth(32),
    .DataWidth(32),
    .MemoryResponseLatency(LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i),
    .q_write_i(q_write_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
    .p_valid_o(p_valid_o), .p_data_o(p_data_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural SRAM: one-cycle read latency, whole-word writes.
  logic        tb_init = 1'b1;
  logic [31:0] mem [256];
  always @(posedge clk_i) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h08] <= 32'hAABBCCDD;
      mem[8'h0C] <= 32'h12345678;
      mem[8'h20] <= 32'h00000055;
      for (int i = 0; i < 8; i++) mem[8'h30 + i] <= 32'h1000 + i;
    end else if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o[7:0]] <= sram_wdata_o;
      else           sram_rdata_i <= mem[sram_addr_o[7:0]];
    end
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t exp_q [$];

  // Response scoreboard: every cycle, p_valid_o must match exactly the due list.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("p_valid", {63'd0, p_valid_o}, 64'd1);
      chk("p_data", {32'd0, p_data_o}, {32'd0, exp_q[0].data});
      void'(exp_q.pop_front());
    end else begin
      chk("p_valid_idle", {63'd0, p_valid_o}, 64'd0);
    end
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    q_valid_i = v; q_write_i = w; q_addr_i = a; q_data_i = d; q_strb_i = s;
  endtask

  task automatic expect_rsp(input logic [31:0] d);
    exp_t e;
    e.due  = cyc + LAT;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Issue a read this cycle and check the SRAM command it produces.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, 32'h0, 4'h0);
    expect_rsp(d);
    @(negedge clk_i);
    chk("rd_ready", {63'd0, q_ready_o}, 64'd1);
    chk("rd_req", {62'd0, sram_req_o, sram_we_o}, 64'b10);
    chk("rd_addr", {32'd0, sram_addr_o}, {32'd0, a});
    step();
  endtask

  initial begin
    // Reset, with a request presented to show it is ignored.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step(); step();
    tb_init = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", {63'd0, q_ready_o}, 64'd0);
    chk("rst_req", {63'd0, sram_req_o}, 64'd0);
    chk("rst_pdata", {32'd0, p_data_o}, 64'd0);
    step();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("post_rst_ready", {63'd0, q_ready_o}, 64'd1);
    chk("idle_noreq", {63'd0, sram_req_o}, 64'd0);
    step();

    // Single read with latency 3.
    do_read(32'h10, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) step();

    // Full write then read of the same word on the next cycle.
    drive(1'b1, 1'b1, 32'h4, 32'h11223344, 4'hF);
    expect_rsp(32'h0);
    @(negedge clk_i);
    chk("fw_ready", {63'd0, q_ready_o}, 64'd1);
    chk("fw_req", {62'd0, sram_req_o, sram_we_o}, 64'b11);
    chk("fw_wdata", {32'd0, sram_wdata_o}, 64'h11223344);
    step();
    do_read(32'h4, 32'h11223344);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) step();

    // Partial write: read old word, then merged write while not ready.
    drive(1'b1, 1'b1, 32'h8, 32'h00001122, 4'b0011);
    expect_rsp(32'h0);
    @(negedge clk_i);
    chk("pw_rd_req", {62'd0, sram_req_o, sram_we_o}, 64'b10);
    chk("pw_rd_addr", {32'd0, sram_addr_o}, 64'h8);
    step();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("merge_ready", {63'd0, q_ready_o}, 64'd0);
    chk("merge_req", {62'd0, sram_req_o, sram_we_o}, 64'b11);
    chk("merge_addr", {32'd0, sram_addr_o}, 64'h8);
    chk("merge_wdata", {32'd0, sram_wdata_o}, 64'hAABB1122);
    step();
    do_read(32'h8, 32'hAABB1122);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) step();

    // Zero-strobe write: no SRAM access, response still returned.
    drive(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    expect_rsp(32'h0);
    @(negedge clk_i);
    chk("zs_ready", {63'd0, q_ready_o}, 64'd1);
    chk("zs_req", {63'd0, sram_req_o}, 64'd0);
    step();
    do_read(32'h20, 32'h00000055);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) step();

    // Eight back-to-back reads.
    for (int i = 0; i < 8; i++) do_read(32'h30 + i, 32'h1000 + i);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (5) step();

    // Reset asserted in the merge cycle abandons the write and its response.
    drive(1'b1, 1'b1, 32'hC, 32'hFFFFFFFF, 4'b0001);
    @(negedge clk_i);
    chk("rm_rd_req", {62'd0, sram_req_o, sram_we_o}, 64'b10);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rm_we", {63'd0, sram_we_o}, 64'd0);
    chk("rm_req", {63'd0, sram_req_o}, 64'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rm_ready_after", {63'd0, q_ready_o}, 64'd1);
    chk("rm_mem_unchanged", {32'd0, mem[8'h0C]}, 64'h12345678);
    step();
    do_read(32'hC, 32'h12345678);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) step();

    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cva6v_vector_bank_ctrl.md
CVA6V_VECTOR_BANK_CTRL -- requirements
Module: cva6v_vector_bank_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, word address width on the bank port (at least 1).
REQ-002 SHALL have parameter DataWidth, default 32, word width in bits (multiple of 8); StrbWidth = DataWidth/8.
REQ-003 SHALL have parameter MemoryResponseLatency, default 1, cycles from request accept to response (at least 1).
REQ-004 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i, input, 1, reset: asynchronous assertion, active-high.
REQ-006 SHALL have q_valid_i, input, 1, request valid from one fabric memory port.
REQ-007 SHALL have q_ready_o, output, 1, request accepted when q_valid_i & q_ready_o.
REQ-008 SHALL have q_addr_i, input, AddrWidth, word address.
REQ-009 SHALL have q_write_i, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have q_data_i, input, DataWidth, write data.
REQ-011 SHALL have q_strb_i, input, StrbWidth, byte write enables.
REQ-012 SHALL have p_valid_o, output, 1, response valid.
REQ-013 SHALL have p_data_o, output, DataWidth, read data for the response.
REQ-014 SHALL have sram_req_o, output, 1, SRAM access enable.
REQ-015 SHALL have sram_we_o, output, 1, SRAM whole-word write enable; the macro has no byte enables.
REQ-016 SHALL have sram_addr_o, output, AddrWidth, SRAM address.
REQ-017 SHALL have sram_wdata_o, output, DataWidth, SRAM write data.
REQ-018 SHALL have sram_rdata_i, input, DataWidth, SRAM read data; valid 1 cycle after a read is issued.

Function
REQ-019 SHALL implement FSM states IDLE and MERGE.
REQ-020 SHALL drive q_ready_o=1 in IDLE and q_ready_o=0 in MERGE.
REQ-021 SHALL, in IDLE on accepting a read, drive sram_req_o=1, sram_we_o=0, sram_addr_o=q_addr_i in the same cycle.
REQ-022 SHALL, in IDLE on accepting a write with q_strb_i all ones, drive sram_req_o=1, sram_we_o=1 and sram_wdata_o=q_data_i in the same cycle.
REQ-023 SHALL, in IDLE on accepting a write with q_strb_i all zeros, drive sram_req_o=0 and issue no SRAM access; the response is still generated.
REQ-024 SHALL, in IDLE on accepting a write with a partial q_strb_i, issue a SRAM read of q_addr_i, register the address, data and strobe, and enter MERGE.
REQ-025 SHALL, in MERGE, drive sram_req_o=1 and sram_we_o=1 at the registered address.
REQ-026 SHALL, in MERGE, drive sram_wdata_o with, per byte b, the registered data byte where registered strobe bit b is 1, else sram_rdata_i byte b.
REQ-027 SHALL return from MERGE to IDLE after exactly one cycle.
REQ-028 SHALL drive sram_req_o=0 whenever no access is defined by REQ-021 to REQ-026.
REQ-029 SHALL assert p_valid_o exactly MemoryResponseLatency cycles after each accept, one response per accept, in accept order.
REQ-030 SHALL implement the response timing with a (MemoryResponseLatency-1)-stage register pipeline fed by the SRAM read data.
REQ-031 SHALL, for a read, set p_data_o to the SRAM word at the address, including the effect of any write accepted earlier.
REQ-032 SHALL, for a write, set p_data_o to all zeros.
REQ-033 SHALL have no backpressure on the response path; p_valid_o is never stalled.
REQ-034 SHALL keep the maximum request throughput at 1 per cycle, except 1 per 2 cycles for partial writes.
REQ-035 SHALL, when q_valid_i=0 in IDLE, hold state and make no SRAM access.

Reset
REQ-036 SHALL, while rst_i=1, force the state to IDLE, p_valid_o=0, p_data_o=0 and sram_req_o=0.
REQ-037 SHALL, while rst_i=1, clear all response pipeline valid bits and drive q_ready_o=0.
REQ-038 SHALL drive q_ready_o=1 in the first cycle after rst_i deasserts.
REQ-039 SHALL, on reset asserted mid-MERGE, abandon the merge write; no SRAM write occurs and no response is delivered for that request.

Verification
REQ-040 SHALL cover: MemoryResponseLatency=3, read addr 0x10 holding 0xDEADBEEF accepted at cycle 5 -> p_valid_o=1 and p_data_o=0xDEADBEEF at cycle 8, and at no other cycle.
REQ-041 SHALL cover: full write 0x11223344 to addr 4, then a read of addr 4 on the next cycle -> the read returns 0x11223344; q_ready_o stays 1 throughout.
REQ-042 SHALL cover: addr 8 holding 0xAABBCCDD, write data 0x00001122 with strb 0b0011 -> q_ready_o=0 for one cycle, SRAM write of 0xAABB1122, a later read returns 0xAABB1122.
REQ-043 SHALL cover: a write with strb 0 -> no sram_req_o, p_valid_o with p_data_o=0 after the latency.
REQ-044 SHALL cover: back-to-back reads for 8 consecutive cycles -> 8 consecutive p_valid_o pulses in order, with no gaps.
REQ-045 SHALL cover: rst_i asserted during MERGE -> sram_we_o=0, p_valid_o=0, the memory word is unchanged, and q_ready_o=1 after release.
